// File: rtl/fib_zeck_encoder.sv
// Sequential Zeckendorf encoder, 16-bit binary -> 64-bit Fibonacci code; FIB_STOP_BIT_EN adds the "11" comma bit.
// Latency: ready_o rises NFIB clocks after the accept edge, independent of data.
// Backpressure: result is held in DONE while en_encode stays high; a new start needs en_encode low first.
module fib_zeck_encoder #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 64,
  parameter int NFIB  = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_encode,
  input  logic [IN_W-1:0]  input_binary,
  output logic             busy_o,
  output logic             ready_o,
  output logic [OUT_W-1:0] data_o
);

  localparam int IDX_W = $clog2(NFIB);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IN_W-1:0]  rem, rem_nxt;
  logic [NFIB-1:0]  code, code_nxt, code_upd;
  logic [OUT_W-1:0] data_nxt, final_word;
  logic [16:0]      weight;
  logic             take;

  // Weight of code bit i is F(i+2).
  function automatic logic [16:0] fib_weight(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:  fib_weight = 17'd1;
      1:  fib_weight = 17'd2;
      2:  fib_weight = 17'd3;
      3:  fib_weight = 17'd5;
      4:  fib_weight = 17'd8;
      5:  fib_weight = 17'd13;
      6:  fib_weight = 17'd21;
      7:  fib_weight = 17'd34;
      8:  fib_weight = 17'd55;
      9:  fib_weight = 17'd89;
      10: fib_weight = 17'd144;
      11: fib_weight = 17'd233;
      12: fib_weight = 17'd377;
      13: fib_weight = 17'd610;
      14: fib_weight = 17'd987;
      15: fib_weight = 17'd1597;
      16: fib_weight = 17'd2584;
      17: fib_weight = 17'd4181;
      18: fib_weight = 17'd6765;
      19: fib_weight = 17'd10946;
      20: fib_weight = 17'd17711;
      21: fib_weight = 17'd28657;
      22: fib_weight = 17'd46368;
      default: fib_weight = 17'd0;
    endcase
  endfunction

  always_comb begin
    weight   = fib_weight(idx);
    take     = (32'(rem) >= 32'(weight));
    code_upd = code;
    if (take) code_upd[idx] = 1'b1;
  end

  // Comma terminator sits one above the highest set code bit.
`ifdef FIB_STOP_BIT_EN
  logic [OUT_W-1:0] stop_word;
  always_comb begin
    stop_word = '0;
    for (int i = 0; i < NFIB; i++) begin
      if (code_upd[i]) stop_word = OUT_W'(1) << (i + 1);
    end
    final_word = OUT_W'(code_upd) | stop_word;
  end
`else
  always_comb begin
    final_word = OUT_W'(code_upd);
  end
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rem_nxt   = rem;
    code_nxt  = code;
    data_nxt  = data_o;
    case (state)
      IDLE: begin
        if (en_encode) begin
          state_nxt = SCAN;
          rem_nxt   = input_binary;
          idx_nxt   = IDX_W'(NFIB - 1);
          code_nxt  = '0;
        end
      end
      SCAN: begin
        code_nxt = code_upd;
        rem_nxt  = take ? (rem - IN_W'(weight)) : rem;
        idx_nxt  = idx - 1'b1;
        if (idx == '0) begin
          state_nxt = DONE;
          data_nxt  = final_word;
        end
      end
      DONE: begin
        if (!en_encode) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      rem    <= '0;
      code   <= '0;
      data_o <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      rem    <= rem_nxt;
      code   <= code_nxt;
      data_o <= data_nxt;
    end
  end

  assign busy_o  = (state == SCAN);
  assign ready_o = (state == DONE);

endmodule

// File: tb/tb_fib_zeck_encoder.sv
// Self-checking bench for fib_zeck_encoder: vector table, corner sequences, random values vs. arithmetic model.
module tb_fib_zeck_encoder;

  localparam int NF = 23;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_encode;
  logic [15:0] input_binary;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] data_o;

  int n_cmp = 0;
  int n_err = 0;

  fib_zeck_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .en_encode    (en_encode),
    .input_binary (input_binary),
    .busy_o       (busy_o),
    .ready_o      (ready_o),
    .data_o       (data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] din;
    logic [63:0] plain;
    logic [63:0] stop;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned fib(input int i);
    int unsigned a = 1, b = 2, t;
    for (int k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Greedy largest-weight-first decomposition on plain integers.
  function automatic logic [63:0] ref_code(input int unsigned v);
    logic [63:0] r = '0;
    int unsigned left = v;
    int hi = -1;
    for (int i = NF - 1; i >= 0; i--) begin
      if (left >= fib(i)) begin
        r[i] = 1'b1;
        left -= fib(i);
        if (hi < 0) hi = i;
      end
    end
`ifdef FIB_STOP_BIT_EN
    if (hi >= 0) r[hi + 1] = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [63:0] strip_stop(input logic [63:0] w);
    logic [63:0] r = w;
`ifdef FIB_STOP_BIT_EN
    for (int i = 63; i >= 0; i--) begin
      if (r[i]) begin
        r[i] = 1'b0;
        break;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [63:0] weight_sum(input logic [63:0] w);
    logic [63:0] s = '0;
    for (int i = 0; i < 64; i++) begin
      if (w[i]) s += (i < 40) ? 64'(fib(i)) : 64'hFFFF_FFFF;
    end
    return s;
  endfunction

  // Runs one encode. drop_at >= 0 drops en_encode and perturbs the input after that many scan clocks.
  task automatic do_encode(input string tag, input logic [15:0] v, input int drop_at,
                           output logic [63:0] res);
    int lat = 0;
    int busy_cnt = 0;
    int data_chg = 0;
    logic [63:0] first;
    @(negedge clk);
    input_binary = v;
    en_encode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    first = data_o;
    while (lat < 60) begin
      if (busy_o) busy_cnt++;
      if (data_o !== first) data_chg++;
      if (ready_o) break;
      if (lat == drop_at) begin
        en_encode = 1'b0;
        input_binary = ~v;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = data_o;
    check({tag, " latency"}, 64'(lat), 64'(NF));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(NF));
    check({tag, " no_partial"}, 64'(data_chg), 64'(lat == NF ? 1 : 0) & 64'(first != res));
    if (en_encode) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        check({tag, " ready_hold"}, 64'(ready_o), 64'd1);
      end
      @(negedge clk);
      en_encode = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, " ready_fall"}, 64'(ready_o), 64'd0);
    check({tag, " data_held"}, data_o, res);
  endtask

  vec_t vecs[7];
  logic [63:0] got;
  logic [63:0] plain;
  logic [15:0] v;

  initial begin
    vecs[0] = '{16'h245A, 64'h4AA15,  64'hCAA15};
    vecs[1] = '{16'hFFFF, 64'h505204, 64'hD05204};
    vecs[2] = '{16'h0001, 64'h1,      64'h3};
    vecs[3] = '{16'h0000, 64'h0,      64'h0};
    vecs[4] = '{16'h0002, 64'h2,      64'h6};
    vecs[5] = '{16'h0004, 64'h5,      64'hD};
    vecs[6] = '{16'd100,  64'h214,    64'h614};

    rst = 1'b1;
    en_encode = 1'b1;
    input_binary = 16'h245A;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("reset busy", 64'(busy_o), 64'd0);
      check("reset ready", 64'(ready_o), 64'd0);
      check("reset data", data_o, 64'd0);
    end
    @(negedge clk);
    en_encode = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle after reset", 64'(busy_o), 64'd0);

    for (int i = 0; i < 7; i++) begin
      do_encode($sformatf("vec%0d", i), vecs[i].din, -1, got);
`ifdef FIB_STOP_BIT_EN
      check($sformatf("vec%0d data", i), got, vecs[i].stop);
`else
      check($sformatf("vec%0d data", i), got, vecs[i].plain);
`endif
    end

    // Inputs changed and start dropped mid-scan must not affect the result.
    do_encode("midscan", 16'h245A, 10, got);
    check("midscan data", got, ref_code(32'h245A));

    // Reset in the middle of a scan abandons it and clears outputs.
    @(negedge clk);
    input_binary = 16'h1234;
    en_encode = 1'b1;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("pre-rst busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    en_encode = 1'b0;
    @(posedge clk);
    #1;
    check("midrst busy", 64'(busy_o), 64'd0);
    check("midrst ready", 64'(ready_o), 64'd0);
    check("midrst data", data_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_encode("after_rst", 16'hFFFF, -1, got);
    check("after_rst data", got, ref_code(32'hFFFF));

    for (int b = 0; b < 16; b++) begin
      v = 16'h245A ^ (16'h1 << b);
      do_encode($sformatf("flip%0d", b), v, -1, got);
      check($sformatf("flip%0d data", b), got, ref_code(32'(v)));
      plain = strip_stop(got);
      check($sformatf("flip%0d adjacent", b), plain & (plain >> 1), 64'd0);
      check($sformatf("flip%0d weight_sum", b), weight_sum(plain), 64'(v));
    end

    for (int r = 0; r < 40; r++) begin
      v = 16'($urandom);
      do_encode($sformatf("rnd%0d", r), v, -1, got);
      check($sformatf("rnd%0d data", r), got, ref_code(32'(v)));
      plain = strip_stop(got);
      check($sformatf("rnd%0d weight_sum", r), weight_sum(plain), 64'(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
